// File: rtl/sirv_gnrl_pkg.sv
// rtl/sirv_gnrl_pkg.sv - shared constants and LFSR step helper for sirv_gnrl blocks
//
// Contents:
//   SIRV_LFSR32_POLY       Galois feedback taps for the 32-bit right-shifting LFSR
//   SIRV_LFSR32_DFLT_SEED  default nonzero reset value
//   sirv_lfsr32_step()     one right-shift Galois step
package sirv_gnrl_pkg;

    localparam logic [31:0] SIRV_LFSR32_POLY      = 32'h8020_0003;
    localparam logic [31:0] SIRV_LFSR32_DFLT_SEED = 32'hACE1_2468;

    // Shift right; when the bit falling out is 1, fold the taps back in.
    function automatic logic [31:0] sirv_lfsr32_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? SIRV_LFSR32_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/sirv_gnrl_lfsr32.sv
// rtl/sirv_gnrl_lfsr32.sv - 32-bit Galois LFSR with load and advance enables
//
// Ports:
//   clk     clock
//   rst     asynchronous reset, active-high; q returns to RST_SEED
//   adv     advance one step on the next edge
//   ld      load ld_val on the next edge (priority over adv)
//   ld_val  load value; zero would lock the LFSR, so it is loaded as 1
//   q       current LFSR state
module sirv_gnrl_lfsr32
    import sirv_gnrl_pkg::*;
#(
    parameter logic [31:0] RST_SEED = SIRV_LFSR32_DFLT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        ld,
    input  logic [31:0] ld_val,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_SEED;
        end else if (ld) begin
            q <= (ld_val == 32'h0) ? 32'h1 : ld_val;
        end else if (adv) begin
            q <= sirv_lfsr32_step(q);
        end
    end

endmodule

// File: rtl/sirv_gnrl_xpoison.sv
// rtl/sirv_gnrl_xpoison.sv - inline valid/ready bus poisoner and handshake-stability checker
//
// Build options:
//   FPGA_SOURCE              defined: module is not compiled (simulation-only block)
//   SIRV_XPOISON_DRIVE_X_EN  defined: poisoned payload is all-x instead of LFSR pattern
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_vld/i_rdy/i_dat  producer side (i_rdy = o_rdy)
//   o_vld/o_rdy/o_dat  consumer side (o_vld = i_vld, o_dat poisoned while idle)
//   poison_en       1 = poison idle cycles, 0 = pure passthrough
//   seed_ld, seed   reload the LFSR on the next edge (0 loads as 1)
//   err_clr         clear err_hold
//   err_hold        sticky handshake-stability violation flag
//   poison_cnt      saturating count of poisoned cycles
`ifndef FPGA_SOURCE
module sirv_gnrl_xpoison
    import sirv_gnrl_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          CW       = 16,
    parameter logic [31:0] RST_SEED = SIRV_LFSR32_DFLT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    input  logic          poison_en,
    input  logic          seed_ld,
    input  logic [31:0]   seed,
    input  logic          err_clr,
    output logic          err_hold,
    output logic [CW-1:0] poison_cnt
);

    logic [31:0]   lfsr_q;
    logic [DW-1:0] pat;
    logic [DW-1:0] cap_dat;
    logic          pend;
    logic          poisoned;
    logic          violation;

    assign o_vld    = i_vld;
    assign i_rdy    = o_rdy;
    assign poisoned = poison_en & ~i_vld;

    sirv_gnrl_lfsr32 #(
        .RST_SEED (RST_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .adv    (poisoned & ~seed_ld),
        .ld     (seed_ld),
        .ld_val (seed),
        .q      (lfsr_q)
    );

    // Tile the 32-bit LFSR across the payload width (truncates when DW < 32).
    always_comb begin
        pat = '0;
        for (int i = 0; i < DW; i++) begin
            pat[i] = lfsr_q[i % 32];
        end
    end

`ifdef SIRV_XPOISON_DRIVE_X_EN
    assign o_dat = poisoned ? {DW{1'bx}} : i_dat;
`else
    assign o_dat = poisoned ? pat : i_dat;
`endif

    // A stalled beat (valid without ready) must stay valid with the same data
    // until it is accepted; pend marks that the previous cycle was such a stall.
    assign violation = pend & (~i_vld | (i_dat != cap_dat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            cap_dat <= '0;
        end else begin
            pend <= i_vld & ~o_rdy;
            if (i_vld & ~o_rdy) begin
                cap_dat <= i_dat;
            end
        end
    end

    // Violation beats a simultaneous clear so no error is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_hold <= 1'b0;
        end else if (violation) begin
            err_hold <= 1'b1;
        end else if (err_clr) begin
            err_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poison_cnt <= '0;
        end else if (poisoned && (poison_cnt != {CW{1'b1}})) begin
            poison_cnt <= poison_cnt + CW'(1);
        end
    end

endmodule
`endif

// File: tb/tb_sirv_gnrl_xpoison.sv
// tb/tb_sirv_gnrl_xpoison.sv - directed vector bench for sirv_gnrl_xpoison
module tb_sirv_gnrl_xpoison;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vld, o_rdy, poison_en, seed_ld, err_clr;
    logic [31:0] i_dat, seed;
    logic        i_rdy, o_vld, err_hold;
    logic [31:0] o_dat;
    logic [15:0] poison_cnt;

    // Narrow instance for counter saturation and pattern truncation.
    logic        s_rst;
    logic        s_i_vld, s_o_rdy, s_poison_en, s_seed_ld, s_err_clr;
    logic [7:0]  s_i_dat;
    logic [31:0] s_seed;
    logic        s_i_rdy, s_o_vld, s_err_hold;
    logic [7:0]  s_o_dat;
    logic [3:0]  s_poison_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sirv_gnrl_xpoison #(.DW(32), .CW(16)) u_dut (
        .clk(clk), .rst(rst),
        .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat),
        .poison_en(poison_en), .seed_ld(seed_ld), .seed(seed),
        .err_clr(err_clr), .err_hold(err_hold), .poison_cnt(poison_cnt)
    );

    sirv_gnrl_xpoison #(.DW(8), .CW(4)) u_small (
        .clk(clk), .rst(s_rst),
        .i_vld(s_i_vld), .i_rdy(s_i_rdy), .i_dat(s_i_dat),
        .o_vld(s_o_vld), .o_rdy(s_o_rdy), .o_dat(s_o_dat),
        .poison_en(s_poison_en), .seed_ld(s_seed_ld), .seed(s_seed),
        .err_clr(s_err_clr), .err_hold(s_err_hold), .poison_cnt(s_poison_cnt)
    );

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic        pen;
        logic        sld;
        logic [31:0] sd;
        logic        clr;
        logic [31:0] exp_dat;   // o_dat before the edge
        logic        exp_err;   // err_hold after the edge
        logic [15:0] exp_cnt;   // poison_cnt after the edge
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic vld, logic [31:0] dat, logic rdy, logic pen,
                                logic sld, logic [31:0] sd, logic clr,
                                logic [31:0] ed, logic ee, logic [15:0] ec);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy; v.pen = pen; v.sld = sld;
        v.sd = sd; v.clr = clr; v.exp_dat = ed; v.exp_err = ee; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Poisoned payload is a pattern in the 2-state build and all-x otherwise.
    task automatic chk_dat(input string name, input logic [31:0] act, input logic [31:0] exp,
                           input logic poisoned);
`ifdef SIRV_XPOISON_DRIVE_X_EN
        if (poisoned) begin
            n_tests++;
            if (act !== 32'hxxxx_xxxx) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected all-x", name, act);
            end
        end else begin
            chk(name, act, exp);
        end
`else
        chk(name, act, exp);
`endif
    endtask

    task automatic drive(input vec_t v);
        i_vld = v.vld; i_dat = v.dat; o_rdy = v.rdy; poison_en = v.pen;
        seed_ld = v.sld; seed = v.sd; err_clr = v.clr;
    endtask

    initial begin
        // Stall/idle pattern on the main instance; LFSR values follow
        // next = (q >> 1) ^ (q[0] ? 32'h80200003 : 0).
        vecs[0]  = mk(0, 32'h0,         0, 1, 0, 0, 0, 32'hACE1_2468, 0, 1);
        vecs[1]  = mk(0, 32'h0,         0, 1, 0, 0, 0, 32'h5670_9234, 0, 2);
        vecs[2]  = mk(0, 32'h0,         0, 1, 0, 0, 0, 32'h2B38_491A, 0, 3);
        vecs[3]  = mk(1, 32'h1234_5678, 1, 1, 0, 0, 0, 32'h1234_5678, 0, 3);
        vecs[4]  = mk(0, 32'h0,         1, 1, 0, 0, 0, 32'h159C_248D, 0, 4);
        vecs[5]  = mk(1, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 4);
        vecs[6]  = mk(1, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 4);
        vecs[7]  = mk(1, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 4);
        vecs[8]  = mk(1, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 4);
        vecs[9]  = mk(1, 32'hA5A5_A5A5, 1, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 4);
        vecs[10] = mk(1, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 4);
        vecs[11] = mk(1, 32'hA5A5_A5A4, 0, 1, 0, 0, 0, 32'hA5A5_A5A4, 1, 4);
        vecs[12] = mk(1, 32'hA5A5_A5A4, 1, 1, 0, 0, 0, 32'hA5A5_A5A4, 1, 4);
        vecs[13] = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'h0,         0, 4);
        vecs[14] = mk(1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 4);
        vecs[15] = mk(0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 1, 4);
        vecs[16] = mk(1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 1, 4);
        vecs[17] = mk(0, 32'h0BAD_F00D, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 1, 4);
        vecs[18] = mk(0, 32'h0BAD_F00D, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 0, 4);
        vecs[19] = mk(0, 32'h0,         0, 1, 1, 0, 0, 32'h8AEE_1245, 0, 5);
        vecs[20] = mk(0, 32'h0,         0, 1, 0, 0, 0, 32'h0000_0001, 0, 6);
        vecs[21] = mk(0, 32'h0,         0, 1, 0, 0, 0, 32'h8020_0003, 0, 7);

        rst = 1'b1; s_rst = 1'b1;
        i_vld = 0; i_dat = 0; o_rdy = 0; poison_en = 1; seed_ld = 0; seed = 0; err_clr = 0;
        s_i_vld = 0; s_i_dat = 8'h3C; s_o_rdy = 0; s_poison_en = 1;
        s_seed_ld = 0; s_seed = 0; s_err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset err_hold", {31'h0, err_hold}, 32'h0);
        chk("reset poison_cnt", {16'h0, poison_cnt}, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k]);
            #2;
            chk_dat($sformatf("v%0d o_dat", k), o_dat, vecs[k].exp_dat,
                    vecs[k].pen & ~vecs[k].vld);
            chk($sformatf("v%0d o_vld", k), {31'h0, o_vld}, {31'h0, vecs[k].vld});
            chk($sformatf("v%0d i_rdy", k), {31'h0, i_rdy}, {31'h0, vecs[k].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d err_hold", k), {31'h0, err_hold}, {31'h0, vecs[k].exp_err});
            chk($sformatf("v%0d poison_cnt", k), {16'h0, poison_cnt}, {16'h0, vecs[k].exp_cnt});
        end

        // Reset in the middle of a stall: pend must not survive.
        i_vld = 1; i_dat = 32'hDEAD_BEEF; o_rdy = 0; poison_en = 0; err_clr = 0; seed_ld = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_vld = 0; poison_en = 1;
        #2;
        chk("async reset poison_cnt", {16'h0, poison_cnt}, 32'h0);
        chk_dat("async reset lfsr seed", o_dat, 32'hACE1_2468, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        poison_en = 0;
        @(posedge clk);
        #1;
        chk("no error after reset", {31'h0, err_hold}, 32'h0);

        // Narrow instance: 8-bit pattern is the low byte, 4-bit count saturates.
        s_rst = 1'b0;
        #2;
        chk_dat("small o_dat", {24'h0, s_o_dat}, 32'h68, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("small cnt saturate", {28'h0, s_poison_cnt}, 32'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("small cnt no wrap", {28'h0, s_poison_cnt}, 32'hF);
        s_poison_en = 0;
        #2;
        chk("small passthrough", {24'h0, s_o_dat}, 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
